// File: rtl/sdes_arbiter_if.sv
// sdes_arbiter_if: request/response bundle between two S-DES requesters,
// the shared sdes_arbiter and the result consumer.
//   req0_* / req1_* : valid/ready request channels carrying mode, key and data
//   rsp_*           : single valid/ready response channel tagged with rsp_id
//   busy            : arbiter is not idle
//   done_count      : completed response handshakes (CNT_W bits, wraps)
// Modports: master = requesters + consumer side, slave = the arbiter.
interface sdes_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned KEY_W  = 10;
  localparam int unsigned DATA_W = 8;

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_mode;
  logic [KEY_W-1:0]  req0_key;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_mode;
  logic [KEY_W-1:0]  req1_key;
  logic [DATA_W-1:0] req1_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  logic              busy;
  logic [CNT_W-1:0]  done_count;

  modport master (
    output req0_valid, req0_mode, req0_key, req0_data,
    input  req0_ready,
    output req1_valid, req1_mode, req1_key, req1_data,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  busy, done_count
  );

  modport slave (
    input  req0_valid, req0_mode, req0_key, req0_data,
    output req0_ready,
    input  req1_valid, req1_mode, req1_key, req1_data,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output busy, done_count
  );
endinterface

// File: rtl/sdes_arbiter.sv
// sdes_arbiter: round-robin arbiter sharing one S-DES keygen/encrypt/decrypt
// datapath between two requesters. Key schedule and cipher are each one
// registered stage; the result is returned on a single tagged response channel.
// Ports:
//   CLOCK_50 : clock, rising edge
//   reset    : synchronous, active-high
//   bus      : sdes_arbiter_if.slave (requests, response, busy, done_count)
// Optional feature: define SDES_KEY_CACHE_EN to keep the last generated key
// schedule and skip KEYGEN when the granted key matches it.

// Ten-bit key to K1/K2 round subkeys (P10, LS-1 / LS-2, P8).
module sdes_keygen (
  input  logic [9:0] key_i,
  output logic [7:0] k1_o,
  output logic [7:0] k2_o
);
  function automatic logic [7:0] p8(input logic [9:0] v);
    return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
  endfunction

  logic [9:0] p10;
  logic [4:0] l1, r1, l2, r2;

  always_comb begin
    p10  = {key_i[7], key_i[5], key_i[8], key_i[3], key_i[6],
            key_i[0], key_i[9], key_i[1], key_i[2], key_i[4]};
    l1   = {p10[8:5], p10[9]};
    r1   = {p10[3:0], p10[4]};
    l2   = {l1[2:0], l1[4:3]};
    r2   = {r1[2:0], r1[4:3]};
    k1_o = p8({l1, r1});
    k2_o = p8({l2, r2});
  end
endmodule

// Full S-DES block: IP, fk(k1), swap, fk(k2), IP^-1.
module sdes_encryption (
  input  logic [7:0] data_i,
  input  logic [7:0] k1_i,
  input  logic [7:0] k2_i,
  output logic [7:0] data_o
);
  function automatic logic [1:0] s0(input logic [3:0] n);
    logic [1:0] r;
    case ({n[3], n[0], n[2], n[1]})
      4'h0: r = 2'd1;  4'h1: r = 2'd0;  4'h2: r = 2'd3;  4'h3: r = 2'd2;
      4'h4: r = 2'd3;  4'h5: r = 2'd2;  4'h6: r = 2'd1;  4'h7: r = 2'd0;
      4'h8: r = 2'd0;  4'h9: r = 2'd2;  4'ha: r = 2'd1;  4'hb: r = 2'd3;
      4'hc: r = 2'd3;  4'hd: r = 2'd1;  4'he: r = 2'd3;  default: r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] s1(input logic [3:0] n);
    logic [1:0] r;
    case ({n[3], n[0], n[2], n[1]})
      4'h0: r = 2'd0;  4'h1: r = 2'd1;  4'h2: r = 2'd2;  4'h3: r = 2'd3;
      4'h4: r = 2'd2;  4'h5: r = 2'd0;  4'h6: r = 2'd1;  4'h7: r = 2'd3;
      4'h8: r = 2'd3;  4'h9: r = 2'd0;  4'ha: r = 2'd1;  4'hb: r = 2'd0;
      4'hc: r = 2'd2;  4'hd: r = 2'd1;  4'he: r = 2'd0;  default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Round function: EP, subkey mix, S-boxes, P4.
  function automatic logic [3:0] f(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] x;
    logic [3:0] s;
    x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    s = {s0(x[7:4]), s1(x[3:0])};
    return {s[2], s[0], s[1], s[3]};
  endfunction

  logic [7:0] ip;
  logic [3:0] l1, l2;
  logic [7:0] pre;

  always_comb begin
    ip     = {data_i[6], data_i[2], data_i[5], data_i[7],
              data_i[4], data_i[0], data_i[3], data_i[1]};
    l1     = ip[7:4] ^ f(ip[3:0], k1_i);
    l2     = ip[3:0] ^ f(l1, k2_i);
    pre    = {l2, l1};
    data_o = {pre[4], pre[7], pre[5], pre[3], pre[1], pre[6], pre[0], pre[2]};
  end
endmodule

// Decryption is the same network with the subkeys applied in reverse order.
module sdes_decryption (
  input  logic [7:0] data_i,
  input  logic [7:0] k1_i,
  input  logic [7:0] k2_i,
  output logic [7:0] data_o
);
  sdes_encryption u_core (
    .data_i (data_i),
    .k1_i   (k2_i),
    .k2_i   (k1_i),
    .data_o (data_o)
  );
endmodule

module sdes_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  sdes_arbiter_if.slave bus
);
  localparam int unsigned KEY_W  = 10;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, KEYGEN, CRYPT, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mode_q, mode_d;
  logic              id_q, id_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] k1_q, k1_d;
  logic [DATA_W-1:0] k2_q, k2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  done_count_q, done_count_d;
`ifdef SDES_KEY_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [KEY_W-1:0]  cache_key_q, cache_key_d;
`endif

  logic              req_any_c;
  logic              grant_id_c;
  logic              grant_mode_c;
  logic [KEY_W-1:0]  grant_key_c;
  logic [DATA_W-1:0] grant_data_c;
  logic [DATA_W-1:0] kg_k1, kg_k2, enc_out, dec_out;

  sdes_keygen u_keygen (
    .key_i (key_q),
    .k1_o  (kg_k1),
    .k2_o  (kg_k2)
  );

  sdes_encryption u_enc (
    .data_i (data_q),
    .k1_i   (k1_q),
    .k2_i   (k2_q),
    .data_o (enc_out)
  );

  sdes_decryption u_dec (
    .data_i (data_q),
    .k1_i   (k1_q),
    .k2_i   (k2_q),
    .data_o (dec_out)
  );

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    req_any_c    = bus.req0_valid | bus.req1_valid;
    grant_id_c   = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    grant_mode_c = grant_id_c ? bus.req1_mode : bus.req0_mode;
    grant_key_c  = grant_id_c ? bus.req1_key  : bus.req0_key;
    grant_data_c = grant_id_c ? bus.req1_data : bus.req0_data;
  end

  // Readies are gated by reset so a handshake coincident with reset never happens.
  assign bus.req0_ready = (state_q == IDLE) & ~reset & req_any_c & ~grant_id_c;
  assign bus.req1_ready = (state_q == IDLE) & ~reset & req_any_c &  grant_id_c;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = id_q;
  assign bus.busy       = busy_q;
  assign bus.done_count = done_count_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    id_d         = id_q;
    key_d        = key_q;
    data_d       = data_q;
    k1_d         = k1_q;
    k2_d         = k2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    done_count_d = done_count_q;
`ifdef SDES_KEY_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_any_c) begin
          key_d        = grant_key_c;
          mode_d       = grant_mode_c;
          data_d       = grant_data_c;
          id_d         = grant_id_c;
          last_grant_d = grant_id_c;
          state_d      = KEYGEN;
`ifdef SDES_KEY_CACHE_EN
          // K1/K2 still hold the schedule of the cached key on a hit.
          if (cache_valid_q && (cache_key_q == grant_key_c)) begin
            state_d = CRYPT;
          end
`endif
        end
      end
      KEYGEN: begin
        k1_d    = kg_k1;
        k2_d    = kg_k2;
`ifdef SDES_KEY_CACHE_EN
        cache_valid_d = 1'b1;
        cache_key_d   = key_q;
`endif
        state_d = CRYPT;
      end
      CRYPT: begin
        rsp_data_d  = mode_q ? dec_out : enc_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mode_q       <= 1'b0;
      id_q         <= 1'b0;
      key_q        <= '0;
      data_q       <= '0;
      k1_q         <= '0;
      k2_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      done_count_q <= '0;
`ifdef SDES_KEY_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
      key_q        <= key_d;
      data_q       <= data_d;
      k1_q         <= k1_d;
      k2_q         <= k2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      done_count_q <= done_count_d;
`ifdef SDES_KEY_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_key_q   <= cache_key_d;
`endif
    end
  end
endmodule

// File: tb/tb_sdes_arbiter.sv
// tb_sdes_arbiter: directed bench for sdes_arbiter. Runs arbitration, backpressure,
// a table of encrypt/decrypt vectors, reset in the crypt stage and a key reuse
// sequence; response latency expectations follow SDES_KEY_CACHE_EN when defined.
module tb_sdes_arbiter;
  localparam logic [9:0] KEY_A = 10'b1010000010;
  localparam logic [9:0] KEY_Z = 10'b0000000000;

  typedef struct {
    logic       id;
    logic       mode;
    logic [9:0] key;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_done = 0;
  bit   mc_valid = 1'b0;
  logic [9:0] mc_key = '0;
  vec_t vecs [6];

  sdes_arbiter_if #(.CNT_W(16)) bus ();

  sdes_arbiter #(.CNT_W(16)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int exp_lat(input logic [9:0] key);
`ifdef SDES_KEY_CACHE_EN
    return (mc_valid && (mc_key == key)) ? 2 : 3;
`else
    return 3;
`endif
  endfunction

  task automatic drive_req(input logic id, input logic mode, input logic [9:0] key,
                           input logic [7:0] din);
    if (id) begin
      bus.req1_mode = mode; bus.req1_key = key; bus.req1_data = din; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_mode = mode; bus.req0_key = key; bus.req0_data = din; bus.req0_valid = 1'b1;
    end
  endtask

  task automatic wait_hs(input logic id, output bit ok, output int hc);
    ok = 1'b0;
    hc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        hc = cyc;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int rc);
    ok = 1'b0;
    rc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        rc = cyc;
      end
    end
  endtask

  // One request with rsp_ready held high; checks latency, data, id and count.
  task automatic run_txn(input string tag, input vec_t v);
    bit ok;
    int hc, rc, el;
    el = exp_lat(v.key);
    @(posedge clk); #1;
    drive_req(v.id, v.mode, v.key, v.din);
    wait_hs(v.id, ok, hc);
    chk({tag, "_hs"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (v.id) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
    wait_rsp(ok, rc);
    chk({tag, "_rsp"}, 32'(ok), 32'd1);
    chk({tag, "_lat"}, 32'(rc - hc), 32'(el));
    chk({tag, "_data"}, 32'(bus.rsp_data), 32'(v.dout));
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(v.id));
    exp_done++;
    mc_valid = 1'b1;
    mc_key   = v.key;
    @(negedge clk);
    chk({tag, "_done"}, 32'(bus.done_count), 32'(exp_done));
    chk({tag, "_vclr"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int hc, rc, seen;
    logic g;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, KEY_A, 8'b10010111, 8'b00111000};
    vecs[1] = '{1'b1, 1'b1, KEY_A, 8'b00111000, 8'b10010111};
    vecs[2] = '{1'b0, 1'b0, KEY_Z, 8'b00000000, 8'b11110000};
    vecs[3] = '{1'b1, 1'b1, KEY_Z, 8'b11110000, 8'b00000000};
    vecs[4] = '{1'b1, 1'b0, KEY_A, 8'b10010111, 8'b00111000};
    vecs[5] = '{1'b0, 1'b1, KEY_Z, 8'b11110000, 8'b00000000};

    reset = 1'b1;
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_mode = 1'b0; bus.req0_key = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_mode = 1'b0; bus.req1_key = '0; bus.req1_data = '0;
    repeat (3) @(posedge clk);
    #1;
    // Both requesters pending while still in reset.
    drive_req(1'b0, 1'b0, KEY_A, 8'b10010111);
    drive_req(1'b1, 1'b1, KEY_A, 8'b00111000);
    @(negedge clk);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;

    // Arbitration: both continuously valid, grants alternate starting with 0.
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      g  = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        if (bus.req0_ready | bus.req1_ready) begin
          ok = 1'b1;
          g  = bus.req1_ready;
        end
      end
      chk($sformatf("arb%0d_hs", i), 32'(ok), 32'd1);
      chk($sformatf("arb%0d_grant", i), 32'(g), 32'(i % 2));
      chk($sformatf("arb%0d_both", i), 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      wait_rsp(ok, rc);
      chk($sformatf("arb%0d_rsp", i), 32'(ok), 32'd1);
      chk($sformatf("arb%0d_id", i), 32'(bus.rsp_id), 32'(i % 2));
      chk($sformatf("arb%0d_data", i), 32'(bus.rsp_data),
          (i % 2 == 0) ? 32'b00111000 : 32'b10010111);
      chk($sformatf("arb%0d_busy", i), 32'(bus.busy), 32'd1);
      exp_done++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("arb_done", 32'(bus.done_count), 32'd4);
    mc_valid = 1'b1;
    mc_key   = KEY_A;

    // Backpressure: response held for 5 cycles while req1 waits.
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, KEY_Z, 8'b00000000);
    wait_hs(1'b0, ok, hc);
    chk("bp_hs", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drive_req(1'b1, 1'b1, KEY_Z, 8'b11110000);
    wait_rsp(ok, rc);
    chk("bp_rsp", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_data", i), 32'(bus.rsp_data), 32'b11110000);
      chk($sformatf("bp%0d_id", i), 32'(bus.rsp_id), 32'd0);
      chk($sformatf("bp%0d_rdy", i), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      chk($sformatf("bp%0d_done", i), 32'(bus.done_count), 32'(exp_done));
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_cycle_rdy1", 32'(bus.req1_ready), 32'd0);
    exp_done++;
    @(negedge clk);
    chk("bp_done", 32'(bus.done_count), 32'(exp_done));
    chk("bp_next_rdy1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_rsp(ok, rc);
    chk("bp2_rsp", 32'(ok), 32'd1);
    chk("bp2_data", 32'(bus.rsp_data), 32'd0);
    chk("bp2_id", 32'(bus.rsp_id), 32'd1);
    exp_done++;
    mc_valid = 1'b1;
    mc_key   = KEY_Z;
    @(negedge clk);
    chk("bp2_done", 32'(bus.done_count), 32'(exp_done));

    // Vector table.
    for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset while the transaction sits in CRYPT.
    hc = exp_lat(KEY_A);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, KEY_A, 8'b10010111);
    wait_hs(1'b0, ok, rc);
    chk("rstc_hs", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    if (hc == 3) begin
      @(posedge clk); #1;
    end
    chk("rstc_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstc_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstc_busy", 32'(bus.busy), 32'd0);
    chk("rstc_data", 32'(bus.rsp_data), 32'd0);
    chk("rstc_id", 32'(bus.rsp_id), 32'd0);
    chk("rstc_done", 32'(bus.done_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_done = 0;
    mc_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("rstc_no_rsp", 32'(seen), 32'd0);
    run_txn("post_rst", vecs[0]);

    // Key reuse: same key twice, then a new key.
    run_txn("reuse0", vecs[0]);
    run_txn("reuse1", vecs[4]);
    v = vecs[2];
    run_txn("reuse2", v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
